pc_sequencer: RTL and testbench
===============================

# pc_sequencer

Program-counter sequencer for the processor core. It owns the 10-bit `PC` and requests instruction fetches from instruction memory with a req/ack handshake. At each instruction boundary it selects the next `PC` from return, call, branch (`BADR`) or sequential increment. It also handles halt/resume and keeps a small hardware return-address stack with sticky overflow/underflow fault detection.

## Interface
- `DEPTH`, 4: return-stack entries (2..16).
- `RESET_ADDR`, 10'd0: `PC` value loaded on reset.

- `clk`  in  1  system clock, rising-edge.
- `rst`  in  1  asynchronous, active-high reset.
- `hlt`  in  1  halt request, sampled at instruction boundary.
- `bra`  in  1  branch: next `PC` = `BADR`.
- `call`  in  1  call: push `PC`+1, next `PC` = `BADR`.
- `ret`  in  1  return: next `PC` = popped stack top.
- `BADR`  in  10  branch/call target address.
- `fetch_ack`  in  1  instruction memory has returned the word at `PC`; marks the instruction boundary.
- `fetch_req`  out  1  fetch request for the word at `PC`.
- `PC`  out  10  current program counter.
- `halted`  out  1  sequencer is in HALTED.
- `fault`  out  1  sticky stack overflow/underflow flag.
- `sp`  out  $clog2(DEPTH+1)  number of valid stack entries.

## Operation
- States:
  - IDLE: one cycle after reset.
  - FETCH: `fetch_req`=1, waiting for ack.
  - HALTED.
  - FAULT.
- Transitions:
  - IDLE -> FETCH unconditionally.
  - FETCH stays in FETCH while `fetch_ack`=0; `PC` and stack hold.
  - FETCH with `fetch_ack`=1 (boundary) updates `PC` and the stack, then goes to HALTED if `hlt`=1, else stays in FETCH.
  - HALTED -> FETCH when `hlt`=0; otherwise holds.
  - FAULT is terminal until `rst`.
- Next-`PC` priority at a boundary: `ret` > `call` > `bra` > `PC`+1. Lower-priority controls asserted in the same cycle are ignored.
- `ret`:
  - `sp`>0: `PC` = entry[`sp`-1], `sp` decrements.
  - `sp`=0: underflow. Enter FAULT, set `fault`, `PC` holds.
- `call`:
  - `sp`<`DEPTH`: entry[`sp`] = `PC`+1 (mod 1024), `sp` increments, `PC` = `BADR`.
  - `sp`=`DEPTH`: overflow. Enter FAULT, set `fault`, `PC` and stack hold.
- Arithmetic: `PC`+1 is 10-bit modulo, so 10'd1023 -> 10'd0 with no flag. The pushed return address wraps the same way.
- `hlt` together with other controls at a boundary: the `PC`/stack update completes first, then the block halts. `PC` then points at the next instruction to fetch.
- Controls other than `hlt` are ignored outside the FETCH ack cycle (IDLE, HALTED, FAULT, and FETCH with `fetch_ack`=0).
- Outputs:
  - `fetch_req` = (state==FETCH).
  - `halted` = (state==HALTED).
  - `fault` = (state==FAULT).
  - All outputs are registered state or direct decodes of state; no input-to-output combinational path.

## Timing
- Reset (asynchronous, any cycle, including mid-fetch or while HALTED/FAULT):
  - `PC`=`RESET_ADDR`, `sp`=0, state=IDLE.
  - `fetch_req`=0, `halted`=0, `fault`=0.
  - Stack contents are don't-care.
  - A pending fetch is abandoned; memory must tolerate a dropped request.
- After `rst` deasserts: first rising edge enters FETCH, so `fetch_req`=1 one cycle after release.
- Next-`PC` latency: 1 cycle. `PC` changes on the rising edge that samples `fetch_ack`=1.
- Back-to-back: with `fetch_ack` held high, `PC` advances every cycle.
- Halt:
  - `halted` rises on the edge after the boundary with `hlt`=1.
  - Resume: `fetch_req` rises on the edge after `hlt` is sampled 0 in HALTED.
  - Minimum halt is 1 cycle.
- Fault: `fault` rises on the edge after the offending boundary; `fetch_req` drops on the same edge.
- `fetch_ack` while `fetch_req`=0 is ignored.

## Test plan
- Reset/sequential:
  - Stimulus: `rst` pulse, `RESET_ADDR`=0, `fetch_ack` tied 1, no controls.
  - Response: `fetch_req`=0 in IDLE; `PC` then reads 0,1,2,3… one per cycle. Preload 1022 via branch: 1022 -> 1023 -> 0.
- Branch + wait states:
  - Stimulus: `bra`=1, `BADR`=10'd15 at a boundary; then `fetch_ack` low 3 cycles.
  - Response: `PC`=15 next cycle and held 15 for 3 cycles; 16 after the next ack.
- Call/return:
  - Stimulus: at `PC`=5, `call` with `BADR`=100; at `PC`=102, `ret`.
  - Response: `sp` 0->1->0; `PC` 5 -> 100 -> 101 -> 102 -> 6.
  - Simultaneous `call`+`bra`+`ret` with `sp`=1: ret wins.
- Halt:
  - Stimulus: `hlt`=1 together with `bra`, `BADR`=15, at a boundary; hold `hlt` 3 cycles.
  - Response: `PC`=15, `halted`=1, `fetch_req`=0 for 3 cycles; `fetch_req`=1 one cycle after `hlt`=0.
- Stack faults:
  - `DEPTH`=4: 5 consecutive calls -> `sp`=4 and `fault`=1 after the 5th; `PC` frozen; only `rst` clears.
  - Fresh reset then `ret` -> `fault`=1, `PC` holds `RESET_ADDR`.
- Async reset mid-operation:
  - Stimulus: assert `rst` between clock edges while `sp`=2 and HALTED.
  - Response: immediately `PC`=0, `sp`=0, `halted`=0, with no clock edge needed.

Source files
------------

// File: rtl/pc_sequencer_if.sv
// Fetch/control bundle between the program-counter sequencer and its environment.
// The master side is the sequencer; the slave side is the control unit plus instruction memory.
interface pc_sequencer_if #(
  parameter int unsigned DEPTH = 4
) ();
  logic                             hlt;
  logic                             bra;
  logic                             call;
  logic                             ret;
  logic [9:0]                       BADR;
  logic                             fetch_ack;
  logic                             fetch_req;
  logic [9:0]                       PC;
  logic                             halted;
  logic                             fault;
  logic [$clog2(DEPTH+1)-1:0]       sp;

  modport master (
    input  hlt, bra, call, ret, BADR, fetch_ack,
    output fetch_req, PC, halted, fault, sp
  );

  modport slave (
    output hlt, bra, call, ret, BADR, fetch_ack,
    input  fetch_req, PC, halted, fault, sp
  );
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: owns PC, issues fetch requests, selects ret/call/branch/increment
// at each acknowledged fetch, and keeps a return-address stack with sticky fault on misuse.
module pc_sequencer #(
  parameter int unsigned DEPTH      = 4,
  parameter logic [9:0]  RESET_ADDR = 10'd0
) (
  input logic           clk,
  input logic           rst,
  pc_sequencer_if.master bus
);

  localparam int unsigned SpW  = $clog2(DEPTH + 1);
  localparam int unsigned IdxW = $clog2(DEPTH);
  localparam logic [SpW-1:0] SpFull = SpW'(DEPTH);

  typedef enum logic [1:0] {StIdle, StFetch, StHalted, StFault} state_e;

  state_e         state_q, state_d;
  logic [9:0]     pc_q, pc_d;
  logic [SpW-1:0] sp_q, sp_d;
  logic [9:0]     stack_q [DEPTH];

  logic            push_en;
  logic [IdxW-1:0] push_idx;
  logic [IdxW-1:0] pop_idx;
  logic [9:0]      pc_inc;
  state_e          after_boundary;

  assign pc_inc         = pc_q + 10'd1;
  assign push_idx       = IdxW'(sp_q);
  assign pop_idx        = IdxW'(sp_q - SpW'(1));
  assign after_boundary = bus.hlt ? StHalted : StFetch;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    sp_d    = sp_q;
    push_en = 1'b0;
    unique case (state_q)
      StIdle: state_d = StFetch;
      StFetch: begin
        if (bus.fetch_ack) begin
          // ret > call > bra > increment; a fault leaves PC and stack untouched
          if (bus.ret) begin
            if (sp_q != '0) begin
              pc_d    = stack_q[pop_idx];
              sp_d    = sp_q - SpW'(1);
              state_d = after_boundary;
            end else begin
              state_d = StFault;
            end
          end else if (bus.call) begin
            if (sp_q != SpFull) begin
              push_en = 1'b1;
              pc_d    = bus.BADR;
              sp_d    = sp_q + SpW'(1);
              state_d = after_boundary;
            end else begin
              state_d = StFault;
            end
          end else if (bus.bra) begin
            pc_d    = bus.BADR;
            state_d = after_boundary;
          end else begin
            pc_d    = pc_inc;
            state_d = after_boundary;
          end
        end
      end
      StHalted: begin
        if (!bus.hlt) state_d = StFetch;
      end
      StFault: state_d = StFault;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      pc_q    <= RESET_ADDR;
      sp_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      sp_q    <= sp_d;
    end
  end

  // Stack contents are don't-care after reset, so the storage carries no reset.
  always_ff @(posedge clk) begin
    if (push_en) stack_q[push_idx] <= pc_inc;
  end

  assign bus.fetch_req = (state_q == StFetch);
  assign bus.halted    = (state_q == StHalted);
  assign bus.fault     = (state_q == StFault);
  assign bus.PC        = pc_q;
  assign bus.sp        = sp_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed and randomized bench for pc_sequencer against a queue-based behavioural model.
module tb_pc_sequencer;

  localparam int unsigned DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;

  pc_sequencer_if #(.DEPTH(DEPTH)) bus ();

  pc_sequencer #(.DEPTH(DEPTH), .RESET_ADDR(10'd0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model: PC as an integer, return stack as a queue, mode flags.
  int m_pc;
  int m_stack[$];
  bit m_idle, m_halted, m_fault;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    bit running;
    running = !(m_idle || m_halted || m_fault);
    chk({tag, ".PC"}, 32'(bus.PC), 32'(m_pc));
    chk({tag, ".sp"}, 32'(bus.sp), 32'(m_stack.size()));
    chk({tag, ".fetch_req"}, 32'(bus.fetch_req), 32'(running));
    chk({tag, ".halted"}, 32'(bus.halted), 32'(m_halted));
    chk({tag, ".fault"}, 32'(bus.fault), 32'(m_fault));
  endtask

  task automatic model_reset();
    m_pc = 0;
    m_stack.delete();
    m_idle = 1'b1;
    m_halted = 1'b0;
    m_fault = 1'b0;
  endtask

  // One rising edge of the model, using the inputs currently on the bus.
  task automatic model_step();
    if (m_idle) begin
      m_idle = 1'b0;
    end else if (m_fault) begin
    end else if (m_halted) begin
      if (!bus.hlt) m_halted = 1'b0;
    end else if (bus.fetch_ack) begin
      if (bus.ret) begin
        if (m_stack.size() == 0) m_fault = 1'b1;
        else begin
          m_pc = m_stack.pop_back();
          m_halted = bus.hlt;
        end
      end else if (bus.call) begin
        if (m_stack.size() == DEPTH) m_fault = 1'b1;
        else begin
          m_stack.push_back((m_pc + 1) % 1024);
          m_pc = int'(bus.BADR);
          m_halted = bus.hlt;
        end
      end else begin
        m_pc = bus.bra ? int'(bus.BADR) : (m_pc + 1) % 1024;
        m_halted = bus.hlt;
      end
    end
  endtask

  task automatic drive(input bit h, input bit b, input bit c, input bit r,
                       input int badr, input bit ack);
    bus.hlt = h;
    bus.bra = b;
    bus.call = c;
    bus.ret = r;
    bus.BADR = 10'(badr);
    bus.fetch_ack = ack;
  endtask

  task automatic cycle(input string tag);
    @(posedge clk);
    model_step();
    #1;
    check_all(tag);
  endtask

  // Asynchronous reset pulse between edges; outputs are checked before any clock edge.
  task automatic do_reset(input string tag);
    #2 rst = 1'b1;
    model_reset();
    #1;
    check_all(tag);
    #2 rst = 1'b0;
  endtask

  initial begin
    drive(0, 0, 0, 0, 0, 0);
    #1;
    do_reset("reset");

    // Sequential run with fetch_ack tied high
    drive(0, 0, 0, 0, 0, 1);
    cycle("idle_to_fetch");
    chk("first_pc", 32'(bus.PC), 32'd0);
    for (int i = 0; i < 3; i++) cycle("seq");
    chk("seq_pc3", 32'(bus.PC), 32'd3);

    // Wrap at the top of the address space
    drive(0, 1, 0, 0, 1022, 1);
    cycle("bra1022");
    drive(0, 0, 0, 0, 0, 1);
    cycle("inc1023");
    cycle("wrap0");
    chk("wrap_pc", 32'(bus.PC), 32'd0);

    // Branch then wait states
    drive(0, 1, 0, 0, 15, 1);
    cycle("bra15");
    drive(0, 1, 1, 1, 77, 0);
    for (int i = 0; i < 3; i++) cycle("wait");
    chk("wait_pc", 32'(bus.PC), 32'd15);
    drive(0, 0, 0, 0, 0, 1);
    cycle("after_wait");
    chk("after_wait_pc", 32'(bus.PC), 32'd16);

    // Call / return
    drive(0, 1, 0, 0, 5, 1);
    cycle("bra5");
    drive(0, 0, 1, 0, 100, 1);
    cycle("call100");
    chk("call_sp", 32'(bus.sp), 32'd1);
    drive(0, 0, 0, 0, 0, 1);
    cycle("inc101");
    cycle("inc102");
    drive(0, 0, 0, 1, 0, 1);
    cycle("ret");
    chk("ret_pc", 32'(bus.PC), 32'd6);
    drive(0, 0, 1, 0, 200, 1);
    cycle("call200");
    drive(0, 1, 1, 1, 300, 1);
    cycle("ret_wins");
    chk("ret_wins_pc", 32'(bus.PC), 32'd7);

    // Halt with a branch at the same boundary; other controls ignored while halted
    drive(1, 1, 0, 0, 15, 1);
    cycle("halt_bra");
    chk("halt_pc", 32'(bus.PC), 32'd15);
    drive(1, 1, 1, 1, 500, 1);
    cycle("halted1");
    cycle("halted2");
    drive(0, 0, 0, 0, 0, 1);
    cycle("resume");
    chk("resume_req", 32'(bus.fetch_req), 32'd1);

    // Overflow: five calls with DEPTH four
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 1, 0, 40 + i, 1);
      cycle("call_chain");
    end
    chk("ovf_fault", 32'(bus.fault), 32'd1);
    chk("ovf_sp", 32'(bus.sp), 32'd4);
    drive(0, 0, 0, 1, 0, 1);
    cycle("fault_hold");
    cycle("fault_hold2");

    // Underflow right after reset
    do_reset("reset2");
    cycle("idle2");
    drive(0, 1, 1, 1, 9, 1);
    cycle("underflow");
    chk("unf_pc", 32'(bus.PC), 32'd0);
    chk("unf_fault", 32'(bus.fault), 32'd1);

    // Async reset while halted with two stack entries
    do_reset("reset3");
    drive(0, 0, 0, 0, 0, 1);
    cycle("idle3");
    drive(0, 0, 1, 0, 60, 1);
    cycle("c1");
    drive(1, 0, 1, 0, 70, 1);
    cycle("c2_halt");
    chk("pre_rst_sp", 32'(bus.sp), 32'd2);
    chk("pre_rst_halted", 32'(bus.halted), 32'd1);
    do_reset("async_rst");

    // Randomized run
    for (int n = 0; n < 600; n++) begin
      if ((m_fault && $urandom_range(0, 3) == 0) || $urandom_range(0, 199) == 0) begin
        do_reset("rand_rst");
      end else begin
        drive($urandom_range(0, 5) == 0, $urandom_range(0, 3) == 0,
              $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
              int'($urandom_range(0, 1023)), $urandom_range(0, 3) != 0);
        cycle("rand");
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
